// File: rtl/bnn_pool_packer_pkg.sv
// Shared definitions for the BNN output stage: FSM states, layer modes and
// default word/address/length widths.
package bnn_pkg;

    localparam int WL_DEF = 112;
    localparam int AW_DEF = 5;
    localparam int LW_DEF = 12;

    localparam logic CONV_MODE = 1'b0;
    localparam logic FCL_MODE  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } stateT;

    // 2x2 binary max-pool of +/-1 values reduces to an OR of the 0/1 encodings.
    function automatic logic poolMax(input logic acc, input logic newBit);
        return acc | newBit;
    endfunction

endpackage

// File: rtl/bnn_pool_packer_counter.sv
// MEM1 word-address counter: synchronous clear wins over enable, wraps mod 2^W.
module COUNTER_NECV #(
    parameter int W = 5
) (
    input  logic         iCLK,
    input  logic         iRSTn,
    input  logic         iCLR,
    input  logic         iEN,
    output logic [W-1:0] oCNT
);

    // address register
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            oCNT <= '0;
        end else if (iCLR) begin
            oCNT <= '0;
        end else if (iEN) begin
            oCNT <= oCNT + W'(1);
        end
    end

endmodule

// File: rtl/bnn_pool_packer.sv
// Pools/passes comparator bits, packs them LSB-first into WL-bit words and
// writes them to MEM1 through a pack + holding double buffer.
module bnn_pool_packer
    import bnn_pkg::*;
#(
    parameter int WL = WL_DEF,
    parameter int AW = AW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic          iCLK,
    input  logic          iRSTn,
    input  logic          iCLR,
    input  logic          iSTART,
    input  logic          iMODE,
    input  logic [LW-1:0] iLEN,
    input  logic          iEN,
    input  logic          iBIT,
    input  logic          iWr_RDY,
    output logic          oREADY,
    output logic          oWr_EN,
    output logic [AW-1:0] oADDR,
    output logic [WL-1:0] oDATA,
    output logic          oDONE,
    output logic          oERR
);

    localparam int IW = $clog2(WL);

    stateT         state_r;
    stateT         stateNext_s;
    logic          mode_r;
    logic [LW-1:0] len_r;
    logic [WL-1:0] packData_r;
    logic [IW-1:0] bitIdx_r;
    logic [LW-1:0] poolCnt_r;
    logic [1:0]    grpCnt_r;
    logic          grpOr_r;
    logic          packFull_r;
    logic [WL-1:0] holdData_r;
    logic          holdValid_r;
    logic          ready_r;
    logic          done_r;
    logic          err_r;

    logic          bitTake_s;
    logic          pooledValid_s;
    logic          pooledBit_s;
    logic [WL-1:0] wordData_s;
    logic          lastBit_s;
    logic          wordDone_s;
    logic          accept_s;
    logic          holdFree_s;
    logic          start_s;
    logic          finalAccept_s;
    logic          readyNext_s;
    logic          addrClr_s;

    // pooling, word-completion and handshake decode
    always_comb begin
        bitTake_s = iEN & ready_r;
        if (mode_r == FCL_MODE) begin
            pooledValid_s = bitTake_s;
            pooledBit_s   = iBIT;
        end else begin
            pooledValid_s = bitTake_s & (grpCnt_r == 2'd3);
            pooledBit_s   = poolMax(grpOr_r, iBIT);
        end
        wordData_s    = packData_r | ({{(WL-1){1'b0}}, pooledBit_s} << bitIdx_r);
        lastBit_s     = pooledValid_s & ((poolCnt_r + LW'(1)) == len_r);
        wordDone_s    = pooledValid_s & ((bitIdx_r == IW'(WL-1)) | lastBit_s);
        accept_s      = holdValid_r & iWr_RDY;
        holdFree_s    = ~holdValid_r | accept_s;
        start_s       = (state_r == IDLE) & iSTART;
        finalAccept_s = (state_r == FLUSH) & accept_s & ~packFull_r;
        // a full pack register that cannot drain this cycle blocks new bits
        readyNext_s   = (stateNext_s == RUN) & ~(packFull_r & ~accept_s)
                        & ~(wordDone_s & ~holdFree_s);
        addrClr_s     = iCLR | start_s;
    end

    // next-state logic
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            IDLE: begin
                if (iSTART) stateNext_s = RUN;
                else        stateNext_s = IDLE;
            end
            RUN: begin
                if (lastBit_s) stateNext_s = FLUSH;
                else           stateNext_s = RUN;
            end
            FLUSH: begin
                if (finalAccept_s) stateNext_s = IDLE;
                else               stateNext_s = FLUSH;
            end
            default: stateNext_s = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state_r <= IDLE;
        end else if (iCLR) begin
            state_r <= IDLE;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // layer config, pack register, counters, holding register and flags
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            mode_r      <= 1'b0;
            len_r       <= '0;
            packData_r  <= '0;
            bitIdx_r    <= '0;
            poolCnt_r   <= '0;
            grpCnt_r    <= 2'd0;
            grpOr_r     <= 1'b0;
            packFull_r  <= 1'b0;
            holdData_r  <= '0;
            holdValid_r <= 1'b0;
            ready_r     <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else if (iCLR) begin
            mode_r      <= 1'b0;
            len_r       <= '0;
            packData_r  <= '0;
            bitIdx_r    <= '0;
            poolCnt_r   <= '0;
            grpCnt_r    <= 2'd0;
            grpOr_r     <= 1'b0;
            packFull_r  <= 1'b0;
            holdData_r  <= '0;
            holdValid_r <= 1'b0;
            ready_r     <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            ready_r <= readyNext_s;
            done_r  <= finalAccept_s;
            err_r   <= err_r | (iEN & ~ready_r);

            if (start_s) begin
                mode_r     <= iMODE;
                len_r      <= iLEN;
                packData_r <= '0;
                bitIdx_r   <= '0;
                poolCnt_r  <= '0;
                grpCnt_r   <= 2'd0;
                grpOr_r    <= 1'b0;
                packFull_r <= 1'b0;
            end else begin
                if (bitTake_s && (mode_r == CONV_MODE)) begin
                    grpCnt_r <= grpCnt_r + 2'd1;
                    grpOr_r  <= (grpCnt_r == 2'd3) ? 1'b0 : poolMax(grpOr_r, iBIT);
                end
                if (pooledValid_s) begin
                    poolCnt_r <= poolCnt_r + LW'(1);
                    if (wordDone_s) begin
                        bitIdx_r <= '0;
                        if (holdFree_s) begin
                            packData_r <= '0;
                        end else begin
                            packData_r <= wordData_s;
                            packFull_r <= 1'b1;
                        end
                    end else begin
                        packData_r <= wordData_s;
                        bitIdx_r   <= bitIdx_r + IW'(1);
                    end
                end else if (accept_s && packFull_r) begin
                    packData_r <= '0;
                    packFull_r <= 1'b0;
                end
            end

            // holding reloads on the accept edge so back-to-back writes need no bubble
            if (accept_s && packFull_r) begin
                holdData_r <= packData_r;
            end else if (wordDone_s && holdFree_s) begin
                holdData_r  <= wordData_s;
                holdValid_r <= 1'b1;
            end else if (accept_s) begin
                holdValid_r <= 1'b0;
            end
        end
    end

    COUNTER_NECV #(
        .W (AW)
    ) uAddrCnt (
        .iCLK  (iCLK),
        .iRSTn (iRSTn),
        .iCLR  (addrClr_s),
        .iEN   (accept_s),
        .oCNT  (oADDR)
    );

    assign oREADY = ready_r;
    assign oWr_EN = holdValid_r;
    assign oDATA  = holdData_r;
    assign oDONE  = done_r;
    assign oERR   = err_r;

endmodule

// File: tb/tb_bnn_pool_packer.sv
// Directed and randomized layers against a word-list reference model.
module tb_bnn_pool_packer;

    localparam int WL = 112;
    localparam int AW = 5;
    localparam int LW = 12;

    logic          iCLK;
    logic          iRSTn;
    logic          iCLR;
    logic          iSTART;
    logic          iMODE;
    logic [LW-1:0] iLEN;
    logic          iEN;
    logic          iBIT;
    logic          iWr_RDY;
    logic          oREADY;
    logic          oWr_EN;
    logic [AW-1:0] oADDR;
    logic [WL-1:0] oDATA;
    logic          oDONE;
    logic          oERR;

    int            vectors;
    int            miscompares;
    logic [WL-1:0] expQ[$];
    logic          stimBits[$];
    logic [AW-1:0] expAddr;
    logic          layerActive;
    logic          doneExp;
    logic          doneSeen;

    bnn_pool_packer #(.WL(WL), .AW(AW), .LW(LW)) dut (
        .iCLK    (iCLK),
        .iRSTn   (iRSTn),
        .iCLR    (iCLR),
        .iSTART  (iSTART),
        .iMODE   (iMODE),
        .iLEN    (iLEN),
        .iEN     (iEN),
        .iBIT    (iBIT),
        .iWr_RDY (iWr_RDY),
        .oREADY  (oREADY),
        .oWr_EN  (oWr_EN),
        .oADDR   (oADDR),
        .oDATA   (oDATA),
        .oDONE   (oDONE),
        .oERR    (oERR)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [WL-1:0] obs, input logic [WL-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, score writes/done, advance.
    task automatic cyc(input logic st, input logic en, input logic b, input logic rdy, input logic clr);
        logic [WL-1:0] w;
        iSTART  = st;
        iEN     = en;
        iBIT    = b;
        iWr_RDY = rdy;
        iCLR    = clr;
        chk("done_pulse", {{(WL-1){1'b0}}, oDONE}, {{(WL-1){1'b0}}, doneExp});
        if (oDONE === 1'b1) doneSeen = 1'b1;
        doneExp = 1'b0;
        if (clr) begin
            expQ.delete();
            layerActive = 1'b0;
        end else if (oWr_EN === 1'b1 && rdy) begin
            chk("write_expected", {{(WL-1){1'b0}}, logic'(expQ.size() > 0)}, {{(WL-1){1'b0}}, 1'b1});
            if (expQ.size() > 0) begin
                w = expQ.pop_front();
                chk("wr_data", oDATA, w);
                chk("wr_addr", {{(WL-AW){1'b0}}, oADDR}, {{(WL-AW){1'b0}}, expAddr});
                expAddr = expAddr + 5'd1;
                if (expQ.size() == 0 && layerActive) begin
                    doneExp     = 1'b1;
                    layerActive = 1'b0;
                end
            end
        end
        @(posedge iCLK);
        @(negedge iCLK);
    endtask

    // Reference: pool (OR of 4 for CONV), then cut into WL-bit words LSB-first.
    task automatic buildExp(input logic mode, input int len);
        logic          pooled[$];
        logic [WL-1:0] w;
        logic          p;
        pooled.delete();
        for (int i = 0; i < len; i++) begin
            if (mode) p = stimBits[i];
            else      p = stimBits[4*i] | stimBits[4*i+1] | stimBits[4*i+2] | stimBits[4*i+3];
            pooled.push_back(p);
        end
        w = '0;
        for (int j = 0; j < len; j++) begin
            w[j % WL] = pooled[j];
            if ((j % WL) == WL - 1 || j == len - 1) begin
                expQ.push_back(w);
                w = '0;
            end
        end
    endtask

    task automatic runLayer(input logic mode, input int len, input int rdyPct);
        int   nb;
        int   idx;
        int   budget;
        logic en;
        logic rdy;
        nb          = mode ? len : 4 * len;
        iMODE       = mode;
        iLEN        = len[LW-1:0];
        expAddr     = '0;
        layerActive = 1'b1;
        doneSeen    = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idx    = 0;
        budget = 20000;
        while (!doneSeen && budget > 0) begin
            en  = (idx < nb) && (oREADY === 1'b1);
            rdy = ($urandom_range(0, 99) < rdyPct);
            cyc(1'b0, en, en ? stimBits[idx] : 1'b0, rdy, 1'b0);
            if (en) idx++;
            budget--;
        end
        chk("layer_done_seen", {{(WL-1){1'b0}}, doneSeen}, {{(WL-1){1'b0}}, 1'b1});
        chk("layer_queue_drained", {{(WL-1){1'b0}}, logic'(expQ.size() == 0)}, {{(WL-1){1'b0}}, 1'b1});
        chk("layer_err_clear", {{(WL-1){1'b0}}, oERR}, '0);
        chk("layer_idle_ready", {{(WL-1){1'b0}}, oREADY}, '0);
    endtask

    task automatic randomLayer(input logic mode, input int len, input int rdyPct);
        stimBits.delete();
        expQ.delete();
        for (int i = 0; i < (mode ? len : 4 * len); i++)
            stimBits.push_back(mode ? logic'($urandom_range(0, 1)) : logic'($urandom_range(0, 7) == 0));
        buildExp(mode, len);
        runLayer(mode, len, rdyPct);
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, "_wr_en"}, {{(WL-1){1'b0}}, oWr_EN}, '0);
        chk({tag, "_addr"},  {{(WL-AW){1'b0}}, oADDR}, '0);
        chk({tag, "_data"},  oDATA, '0);
        chk({tag, "_done"},  {{(WL-1){1'b0}}, oDONE}, '0);
        chk({tag, "_err"},   {{(WL-1){1'b0}}, oERR}, '0);
        chk({tag, "_ready"}, {{(WL-1){1'b0}}, oREADY}, '0);
    endtask

    initial begin
        logic [WL-1:0] ones;
        ones        = {WL{1'b1}};
        vectors     = 0;
        miscompares = 0;
        expAddr     = '0;
        layerActive = 1'b0;
        doneExp     = 1'b0;
        doneSeen    = 1'b0;
        iRSTn = 1'b0; iCLR = 1'b0; iSTART = 1'b0; iMODE = 1'b0;
        iLEN = '0; iEN = 1'b0; iBIT = 1'b0; iWr_RDY = 1'b0;
        repeat (3) @(negedge iCLK);
        chkAllZero("reset");
        iRSTn = 1'b1;
        @(negedge iCLK);
        chkAllZero("post_reset");

        // FCL, one full word of alternating bits starting with 1
        stimBits.delete(); expQ.delete();
        for (int i = 0; i < 112; i++) stimBits.push_back(logic'((i % 2) == 0));
        expQ.push_back({56{2'b01}});
        runLayer(1'b1, 112, 100);

        // CONV, three pooled bits 0,1,1
        stimBits.delete(); expQ.delete();
        for (int i = 0; i < 12; i++) stimBits.push_back(logic'(i == 5 || i >= 8));
        expQ.push_back(112'h6);
        runLayer(1'b0, 3, 100);

        // FCL, 230 ones -> two full words and a 6-bit tail
        stimBits.delete(); expQ.delete();
        for (int i = 0; i < 230; i++) stimBits.push_back(1'b1);
        expQ.push_back(ones);
        expQ.push_back(ones);
        expQ.push_back(112'h3F);
        runLayer(1'b1, 230, 100);

        // Back-pressure: 224 ones with MEM1 stalled, then drain back-to-back
        expQ.delete();
        iMODE = 1'b1; iLEN = 12'd224;
        expAddr = '0; layerActive = 1'b1; doneSeen = 1'b0;
        expQ.push_back(ones);
        expQ.push_back(ones);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 224; i++) begin
            chk("stall_ready", {{(WL-1){1'b0}}, oREADY}, {{(WL-1){1'b0}}, 1'b1});
            if (i == 112) chk("stall_first_word_pending", {{(WL-1){1'b0}}, oWr_EN}, {{(WL-1){1'b0}}, 1'b1});
            if (i == 200) chk("stall_data_stable", oDATA, ones);
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        chk("stall_wr_en", {{(WL-1){1'b0}}, oWr_EN}, {{(WL-1){1'b0}}, 1'b1});
        chk("stall_ready_low", {{(WL-1){1'b0}}, oREADY}, '0);
        chk("stall_addr", {{(WL-AW){1'b0}}, oADDR}, '0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("stall_err_set", {{(WL-1){1'b0}}, oERR}, {{(WL-1){1'b0}}, 1'b1});
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("stall_back_to_back", {{(WL-1){1'b0}}, oWr_EN}, {{(WL-1){1'b0}}, 1'b1});
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("stall_done_seen", {{(WL-1){1'b0}}, doneSeen}, {{(WL-1){1'b0}}, 1'b1});
        chk("stall_err_sticky", {{(WL-1){1'b0}}, oERR}, {{(WL-1){1'b0}}, 1'b1});

        // Mid-layer clear with a pending write
        expQ.delete();
        iMODE = 1'b1; iLEN = 12'd200;
        expAddr = '0; layerActive = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 150; i++) cyc(1'b0, 1'b1, logic'($urandom_range(0, 1)), 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_wr_en", {{(WL-1){1'b0}}, oWr_EN}, '0);
        chk("clr_addr", {{(WL-AW){1'b0}}, oADDR}, '0);
        chk("clr_ready", {{(WL-1){1'b0}}, oREADY}, '0);
        chk("clr_err", {{(WL-1){1'b0}}, oERR}, '0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        randomLayer(1'b1, 150, 80);

        // Randomized layers, including length 1, WL+1 and address wrap
        randomLayer(1'b0, 1, 100);
        randomLayer(1'b0, $urandom_range(2, 150), 60);
        randomLayer(1'b1, 113, 100);
        randomLayer(1'b1, 4000, 70);
        randomLayer(1'b0, $urandom_range(200, 300), 30);
        randomLayer(1'b1, $urandom_range(1, 500), 50);

        // Asynchronous reset while a write is pending
        expQ.delete();
        iMODE = 1'b1; iLEN = 12'd112; layerActive = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 112; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("arst_pre_wr_en", {{(WL-1){1'b0}}, oWr_EN}, {{(WL-1){1'b0}}, 1'b1});
        #2 iRSTn = 1'b0;
        #1 chkAllZero("arst_async");
        @(posedge iCLK);
        #1 chkAllZero("arst_held");
        @(negedge iCLK);
        iRSTn = 1'b1;
        expQ.delete(); doneExp = 1'b0;
        randomLayer(1'b1, 200, 90);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
